// File: rtl/pipe_pkg.sv
// Shared types for the hazard scoreboard: shadow-pipe entry layout and forward-select encoding.
package pipe_pkg;

    // Widest register address a shadow entry can hold; narrower RA_W is zero-extended.
    localparam int unsigned RA_W_MAX = 8;
    localparam int unsigned FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                regwen;
        logic                is_load;
    } shadow_entry_t;

    function automatic int unsigned fw_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: finds the youngest shadow stage writing rs and flags a
// load that is still too young to forward.
module fwd_select import pipe_pkg::*; #(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                        id_valid,
    input  logic [RA_W-1:0]             rs,
    input  logic                        use_rs,
    input  shadow_entry_t               shadow [DEPTH],
    output logic [fw_width(DEPTH)-1:0]  fwd,
    output logic                        load_hit
);

    localparam int unsigned FW = fw_width(DEPTH);

    logic [RA_W_MAX-1:0] rs_ext;

    always_comb begin
        rs_ext           = '0;
        rs_ext[RA_W-1:0] = rs;
    end

    always_comb begin
        fwd      = FW'(FWD_RF);
        load_hit = 1'b0;
        // Walk oldest to youngest so the youngest matching stage is the last writer.
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (id_valid && use_rs && (rs_ext != '0) && shadow[k].valid &&
                shadow[k].regwen && (shadow[k].rd == rs_ext)) begin
                fwd      = FW'(k + 1);
                load_hit = shadow[k].is_load && ((k + 1) < (1 + int'(LOAD_LAT)));
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: shadow pipe of in-flight destinations, load-use stall,
// branch flush, and external freeze with a deferred flush.
module hazard_scoreboard import pipe_pkg::*; #(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [RA_W-1:0]             id_rs1,
    input  logic [RA_W-1:0]             id_rs2,
    input  logic                        id_use_rs1,
    input  logic                        id_use_rs2,
    input  logic [RA_W-1:0]             id_rd,
    input  logic                        id_regwen,
    input  logic                        id_is_load,
    input  logic                        ex_br_taken,
    input  logic                        ext_stall,
    output logic [fw_width(DEPTH)-1:0]  fwd_a,
    output logic [fw_width(DEPTH)-1:0]  fwd_b,
    output logic                        stall_if,
    output logic                        stall_id,
    output logic                        bubble_ex,
    output logic                        flush_ifid,
    output logic                        flush_idex,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            flush_count
);

    localparam int unsigned FW = fw_width(DEPTH);

    shadow_entry_t    shadow_q [DEPTH];
    shadow_entry_t    shadow_d [DEPTH];
    shadow_entry_t    id_entry;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [FW-1:0]    fwd_a_raw, fwd_b_raw;
    logic             hit_a, hit_b;
    logic             do_flush, load_stall;

    fwd_select #(
        .RA_W     (RA_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_a (
        .id_valid (id_valid),
        .rs       (id_rs1),
        .use_rs   (id_use_rs1),
        .shadow   (shadow_q),
        .fwd      (fwd_a_raw),
        .load_hit (hit_a)
    );

    fwd_select #(
        .RA_W     (RA_W),
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_fwd_b (
        .id_valid (id_valid),
        .rs       (id_rs2),
        .use_rs   (id_use_rs2),
        .shadow   (shadow_q),
        .fwd      (fwd_b_raw),
        .load_hit (hit_b)
    );

    always_comb begin
        id_entry                = '0;
        id_entry.valid          = id_valid;
        id_entry.rd[RA_W-1:0]   = id_rd;
        id_entry.regwen         = id_regwen;
        id_entry.is_load        = id_is_load;
    end

    // Freeze beats flush, flush beats load-use.
    always_comb begin
        do_flush   = !ext_stall && (ex_br_taken || pending_q);
        load_stall = !ext_stall && !do_flush && (hit_a || hit_b);
    end

    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ext_stall) begin
            pending_d = pending_q || ex_br_taken;
        end else begin
            pending_d = 1'b0;
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                shadow_d[k] = shadow_q[k-1];
            end
            shadow_d[0] = (do_flush || load_stall) ? '0 : id_entry;
            if (load_stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (do_flush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q    <= '{default: '0};
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational outputs are forced low while reset is held, not only after the next edge.
    always_comb begin
        fwd_a        = reset ? fwd_a_raw : '0;
        fwd_b        = reset ? fwd_b_raw : '0;
        stall_if     = reset && (ext_stall || load_stall);
        stall_id     = reset && (ext_stall || load_stall);
        bubble_ex    = reset && load_stall;
        flush_ifid   = reset && do_flush;
        flush_idex   = reset && do_flush;
        stall_cycles = stall_cnt_q;
        flush_count  = flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven in lockstep, an in-flight
// instruction list model checked every cycle, plus directed literal expectations.
module tb_hazard_scoreboard;

    localparam int CMAX = 7;  // counters are 3 bits wide here so saturation is reachable

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_regwen = 1'b0, id_is_load = 1'b0;
    logic       ex_br_taken = 1'b0, ext_stall = 1'b0;

    logic [1:0] a_fwd_a, a_fwd_b;
    logic       a_stall_if, a_stall_id, a_bubble, a_fl_ifid, a_fl_idex;
    logic [2:0] a_stall_cnt, a_flush_cnt;
    logic [2:0] b_fwd_a, b_fwd_b;
    logic       b_stall_if, b_stall_id, b_bubble, b_fl_ifid, b_fl_idex;
    logic [2:0] b_stall_cnt, b_flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.RA_W(5), .DEPTH(3), .LOAD_LAT(1), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwen(id_regwen), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .ext_stall(ext_stall), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_if(a_stall_if),
        .stall_id(a_stall_id), .bubble_ex(a_bubble), .flush_ifid(a_fl_ifid),
        .flush_idex(a_fl_idex), .stall_cycles(a_stall_cnt), .flush_count(a_flush_cnt)
    );

    hazard_scoreboard #(.RA_W(5), .DEPTH(4), .LOAD_LAT(2), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwen(id_regwen), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
        .ext_stall(ext_stall), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall_if(b_stall_if),
        .stall_id(b_stall_id), .bubble_ex(b_bubble), .flush_ifid(b_fl_ifid),
        .flush_idex(b_fl_idex), .stall_cycles(b_stall_cnt), .flush_count(b_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model: list of in-flight instructions, index 0 = youngest ----------
    int m_depth [2] = '{3, 4};
    int m_ll    [2] = '{1, 2};
    int m_v [2][6];
    int m_rd[2][6];
    int m_w [2][6];
    int m_ld[2][6];
    int m_pend [2];
    int m_stall[2];
    int m_flush[2];

    function automatic int age_of_writer(input int m, input int rs);
        if (rs == 0) return 0;
        for (int a = 1; a <= m_depth[m]; a++)
            if (m_v[m][a-1] != 0 && m_w[m][a-1] != 0 && m_rd[m][a-1] == rs) return a;
        return 0;
    endfunction

    task automatic model_eval(input int m, output int fa, output int fb, output int stl,
                              output int bub, output int fl);
        int hz;
        fa  = (id_valid && id_use_rs1) ? age_of_writer(m, int'(id_rs1)) : 0;
        fb  = (id_valid && id_use_rs2) ? age_of_writer(m, int'(id_rs2)) : 0;
        hz  = 0;
        if (fa != 0 && m_ld[m][fa-1] != 0 && fa < 1 + m_ll[m]) hz = 1;
        if (fb != 0 && m_ld[m][fb-1] != 0 && fb < 1 + m_ll[m]) hz = 1;
        stl = 0; bub = 0; fl = 0;
        if (!reset) begin
            fa = 0; fb = 0;
        end else if (ext_stall) begin
            stl = 1;
        end else if (ex_br_taken || m_pend[m] != 0) begin
            fl = 1;
        end else if (hz != 0) begin
            stl = 1; bub = 1;
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 6; a++) begin
                m_v[m][a] = 0; m_rd[m][a] = 0; m_w[m][a] = 0; m_ld[m][a] = 0;
            end
            m_pend[m] = 0; m_stall[m] = 0; m_flush[m] = 0;
        end
    endtask

    task automatic model_step(input int m);
        int fa, fb, stl, bub, fl;
        model_eval(m, fa, fb, stl, bub, fl);
        if (ext_stall) begin
            if (ex_br_taken) m_pend[m] = 1;
        end else begin
            m_pend[m] = 0;
            for (int a = m_depth[m] - 1; a > 0; a--) begin
                m_v[m][a] = m_v[m][a-1]; m_rd[m][a] = m_rd[m][a-1];
                m_w[m][a] = m_w[m][a-1]; m_ld[m][a] = m_ld[m][a-1];
            end
            if (fl != 0 || bub != 0) begin
                m_v[m][0] = 0; m_rd[m][0] = 0; m_w[m][0] = 0; m_ld[m][0] = 0;
            end else begin
                m_v[m][0] = int'(id_valid); m_rd[m][0] = int'(id_rd);
                m_w[m][0] = int'(id_regwen); m_ld[m][0] = int'(id_is_load);
            end
            if (bub != 0 && m_stall[m] < CMAX) m_stall[m]++;
            if (fl != 0 && m_flush[m] < CMAX) m_flush[m]++;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else for (int m = 0; m < 2; m++) model_step(m);
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    task automatic cmp_inst(input string p, input int m, input logic [31:0] fa,
                            input logic [31:0] fb, input logic si, input logic sd,
                            input logic bu, input logic f1, input logic f2,
                            input logic [31:0] sc, input logic [31:0] fc);
        int efa, efb, estl, ebub, efl;
        model_eval(m, efa, efb, estl, ebub, efl);
        chk({p, " fwd_a"}, fa, efa);
        chk({p, " fwd_b"}, fb, efb);
        chk({p, " stall_if"}, 32'(si), estl);
        chk({p, " stall_id"}, 32'(sd), estl);
        chk({p, " bubble_ex"}, 32'(bu), ebub);
        chk({p, " flush_ifid"}, 32'(f1), efl);
        chk({p, " flush_idex"}, 32'(f2), efl);
        chk({p, " stall_cycles"}, sc, reset ? m_stall[m] : 0);
        chk({p, " flush_count"}, fc, reset ? m_flush[m] : 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_inst("cyc A", 0, 32'(a_fwd_a), 32'(a_fwd_b), a_stall_if, a_stall_id, a_bubble,
                     a_fl_ifid, a_fl_idex, 32'(a_stall_cnt), 32'(a_flush_cnt));
            cmp_inst("cyc B", 1, 32'(b_fwd_a), 32'(b_fwd_b), b_stall_if, b_stall_id, b_bubble,
                     b_fl_ifid, b_fl_idex, 32'(b_stall_cnt), 32'(b_flush_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic br, input logic xs);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regwen = wen; id_is_load = ld; ex_br_taken = br; ext_stall = xs;
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, ld, 1'b0, 1'b0);
    endtask

    task automatic rd_op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic br, input logic xs);
        drv(1'b1, rs1, u1, rs2, u2, 5'd0, 1'b0, 1'b0, br, xs);
    endtask

    task automatic nop(input logic br);
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, br, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwen = 1'b0;
        id_is_load = 1'b0; ex_br_taken = 1'b0; ext_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- directed sequence with literal expectations ----------------
    initial begin
        do_reset();
        chk("reset stall_cycles", 32'(a_stall_cnt), 0);
        chk("reset fwd_a", 32'(a_fwd_a), 0);

        // Forward from a plain ALU writer as it ages through the shadow pipe.
        issue(5'd5, 1'b0);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t1 fwd_a age1", 32'(a_fwd_a), 1);
        chk("t1 no stall", 32'(a_stall_if), 0);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t1 fwd_a age2", 32'(a_fwd_a), 2);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t1 fwd_a age3", 32'(a_fwd_a), 3);
        chk("t1 B fwd_a age3", 32'(b_fwd_a), 3);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t1 A writer retired", 32'(a_fwd_a), 0);
        chk("t1 B fwd_a age4", 32'(b_fwd_a), 4);

        // Load-use: one stall at LOAD_LAT=1, two at LOAD_LAT=2.
        do_reset();
        issue(5'd6, 1'b1);
        rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("t2 A stall_if", 32'(a_stall_if), 1);
        chk("t2 A bubble_ex", 32'(a_bubble), 1);
        chk("t2 B stall_if", 32'(b_stall_if), 1);
        rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("t2 A stall released", 32'(a_stall_if), 0);
        chk("t2 A fwd_b", 32'(a_fwd_b), 2);
        chk("t2 A stall_cycles", 32'(a_stall_cnt), 1);
        chk("t2 B still stalled", 32'(b_stall_if), 1);
        rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("t2 B stall released", 32'(b_stall_if), 0);
        chk("t2 B fwd_b", 32'(b_fwd_b), 3);
        chk("t2 B stall_cycles", 32'(b_stall_cnt), 2);

        // Youngest writer wins; x0 never forwards.
        do_reset();
        issue(5'd7, 1'b0);
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(5'd7, 1'b0);
        rd_op(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t3 youngest wins", 32'(a_fwd_a), 1);
        do_reset();
        issue(5'd0, 1'b0);
        rd_op(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("t3 x0 no forward", 32'(a_fwd_a), 0);

        // Branch in the same cycle as a load-use hazard.
        do_reset();
        issue(5'd6, 1'b1);
        rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        chk("t4 flush_ifid", 32'(a_fl_ifid), 1);
        chk("t4 flush_idex", 32'(a_fl_idex), 1);
        chk("t4 stall_if off", 32'(a_stall_if), 0);
        chk("t4 bubble off", 32'(a_bubble), 0);
        nop(1'b0);
        chk("t4 flush_count", 32'(a_flush_cnt), 1);
        chk("t4 stall_cycles", 32'(a_stall_cnt), 0);
        chk("t4 flush dropped", 32'(a_fl_ifid), 0);

        // Freeze for three cycles with a branch in the middle; flush deferred to release.
        do_reset();
        issue(5'd5, 1'b0);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("t5 freeze stall_if", 32'(a_stall_if), 1);
        chk("t5 freeze bubble", 32'(a_bubble), 0);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("t5 no flush in freeze", 32'(a_fl_ifid), 0);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("t5 shadow frozen", 32'(a_fwd_a), 1);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t5 deferred flush", 32'(a_fl_idex), 1);
        rd_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("t5 flush one cycle", 32'(a_fl_idex), 0);
        chk("t5 shadow resumed", 32'(a_fwd_a), 2);
        chk("t5 flush_count", 32'(a_flush_cnt), 1);

        // Asynchronous reset in the middle of a stall cycle.
        do_reset();
        issue(5'd6, 1'b1);
        rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("t6 stalled before reset", 32'(a_stall_if), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6 reset stall_if", 32'(a_stall_if), 0);
        chk("t6 reset bubble", 32'(a_bubble), 0);
        chk("t6 reset fwd_b", 32'(a_fwd_b), 0);
        chk("t6 reset B stall_id", 32'(b_stall_id), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Drive counters past all-ones and confirm they stick.
        for (int i = 0; i < 9; i++) begin
            issue(5'd6, 1'b1);
            rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
            rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        end
        nop(1'b0);
        chk("t6 stall_cycles saturated", 32'(a_stall_cnt), 7);
        for (int i = 0; i < 9; i++) nop(1'b1);
        nop(1'b0);
        chk("t6 flush_count saturated", 32'(a_flush_cnt), 7);
        issue(5'd6, 1'b1);
        rd_op(5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        nop(1'b0);
        chk("t6 stall_cycles holds", 32'(a_stall_cnt), 7);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined RV32 core. Sits beside the ID stage.
- Keeps its own shadow pipeline of in-flight destination metadata, DEPTH stages deep (stage 1 = EX ... stage DEPTH = WB).
- Produces per-operand forward selects, load-use stalls/bubbles, branch flushes, and an external-stall freeze with deferred flush.
- Supersedes the hard-wired 5-stage assumption: depth and load latency are both configurable.

Parameters:
- RA_W, 5, register-address width.
- DEPTH, 3, number of tracked stages after ID (min 2, max 6).
- LOAD_LAT, 1, extra cycles before load data can be forwarded. Must be less than DEPTH.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RA_W  source register addresses
- id_use_rs1, id_use_rs2  in  1  source register is actually read
- id_rd  in  RA_W  destination register address
- id_regwen  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load
- ex_br_taken  in  1  taken branch/jump resolved in EX; 1-cycle pulse
- ext_stall  in  1  memory not ready; freeze the whole pipe
- fwd_a, fwd_b  out  FW (FW = clog2(DEPTH+1))  0 = register file; k = result of shadow stage k
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- flush_ifid, flush_idex  out  1  kill younger instructions
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles
- flush_count  out  CNT_W  saturating count of flushes issued

Behaviour:
- Reset (reset=0, asynchronous):
  - All shadow entries invalid; pending_flush=0; both counters 0.
  - All 1-bit outputs 0; fwd_a=fwd_b=0.
  - Release takes effect on the next clk edge.
- Shadow entry fields: {valid, rd, regwen, is_load}. An entry "matches" rs when valid & regwen & rd==rs & rd!=0 & use_rs.
- Forward selects are combinational from the shadow state:
  - fwd = lowest k with a match (youngest wins), else 0.
  - A match on x0 never forwards.
  - When id_valid=0, fwd=0.
- Load-use hazard (combinational): the youngest match for either operand is a load at stage k < 1+LOAD_LAT.
  - Response: stall_if=stall_id=bubble_ex=1.
  - Shadow stage 1 receives an invalid entry that cycle.
  - Resulting stall length = 1+LOAD_LAT-k cycles.
- Shift rule, each clk edge when not frozen:
  - Stage k+1 takes stage k; stage DEPTH drops out.
  - Stage 1 takes ID's metadata, or invalid on bubble or flush.
- Taken branch (ex_br_taken=1, ext_stall=0):
  - flush_ifid=flush_idex=1 for one cycle.
  - Stage 1 is loaded invalid. Stage-1 contents (the branch itself) still shift to stage 2.
  - Overrides any load-use stall in the same cycle: stall/bubble outputs forced 0.
- ext_stall=1 (freeze):
  - stall_if=stall_id=1; bubble_ex=0; flush outputs 0.
  - Shadow and counters hold; fwd still driven from the held state.
  - If ex_br_taken arrives during the freeze, pending_flush is set.
- Deferred flush: on the first cycle with ext_stall=0 and pending_flush=1, the flush is issued exactly as for a taken branch, and pending_flush clears.
- Priority: reset > ext_stall > (ex_br_taken | pending_flush) > load-use.
- Counters:
  - stall_cycles increments on each cycle a load-use stall is asserted.
  - flush_count increments on each flush issued.
  - Both saturate at all-ones.

Decomposition:
- Package pipe_pkg holds:
  - shadow-entry struct;
  - FW localparam function;
  - fwd encoding constant FWD_RF=0.
- Sub-module fwd_select (pure combinational, instantiated twice): takes one rs/use pair plus the shadow vector; returns fwd and a load_hit flag.

Test Plan:
1. ADD x5 in stage 1, ID reads rs1=x5 (DEPTH=3) -> fwd_a=1, no stall; two cycles later with the same ID held -> fwd_a=3.
2. LW x6 in stage 1, ID rs2=x6, LOAD_LAT=1 -> stall_if/stall_id/bubble_ex=1 for exactly 1 cycle, then fwd_b=2, stall_cycles=1. Repeat with LOAD_LAT=2 -> 2 stall cycles.
3. Writes to x7 pending in stage 1 and stage 3, ID rs1=x7 -> fwd_a=1 (youngest wins). rd=x0 with regwen=1 -> fwd_a=0.
4. Load-use stall and ex_br_taken in the same cycle -> flush_ifid=flush_idex=1, stall/bubble outputs 0, flush_count=1, stall_cycles unchanged.
5. ext_stall high for 3 cycles with an ex_br_taken pulse in cycle 2 -> no flush and shadow frozen during the stall; flush asserted in the first cycle after release, then 0.
6. Assert reset low mid-stall (mid-cycle, no clk edge) -> all outputs 0 immediately. Force counters to all-ones, then stall -> they remain at all-ones.
